// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (signed/unsigned) with abort and async reset.
// States: DIV_FREE idle | DIV_BY_ZERO divisor was 0 | DIV_ON iterating | DIV_END result held
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic [31:0] op1_mag, op2_mag;
  logic [64:0] work_sh, work_step;
  logic [33:0] trial;
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign accept = start_i && !annul_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE:    if (accept) state_d = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_d = annul_i ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (annul_i)              state_d = DIV_FREE;
        else if (cnt_q == 6'd31)  state_d = DIV_END;
      end
      DIV_END:     if (!start_i) state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
  end

  assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Upper 33 bits hold the partial remainder, lower 32 the dividend/quotient.
  assign work_sh   = work_q << 1;
  assign trial     = {1'b0, work_sh[64:32]} - {2'b00, divisor_q};
  assign work_step = trial[33] ? work_sh : {trial[32:0], work_sh[31:1], 1'b1};

  assign quo_raw = work_step[31:0];
  assign rem_raw = work_step[63:32];
  assign quo_fix = (neg1_q ^ neg2_q) ? (~quo_raw + 32'd1) : quo_raw;
  assign rem_fix = neg1_q ? (~rem_raw + 32'd1) : rem_raw;

  always_comb begin
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
        if (accept && (opdata2_i != 32'd0)) begin
          cnt_d     = 6'd0;
          work_d    = {33'd0, op1_mag};
          divisor_d = op2_mag;
          neg1_d    = signed_div_i && opdata1_i[31];
          neg2_d    = signed_div_i && opdata2_i[31];
        end
      end
      DIV_BY_ZERO: begin
        result_d = 64'd0;
        ready_d  = !annul_i;
        cnt_d    = 6'd0;
      end
      DIV_ON: begin
        if (annul_i) begin
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else begin
          work_d = work_step;
          if (cnt_q == 6'd31) begin
            cnt_d    = 6'd0;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DIV_END: begin
        if (!start_i) begin
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = 64'd0;
        ready_d  = 1'b0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule

// File: tb/tb_div.sv
// Bench for div: arithmetic reference model checked every cycle, plus literal directed checks.
module tb_div;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Protocol-level model: idle / computing for a fixed latency / result held.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_res   = 64'd0;
  logic [63:0] m_out   = 64'd0;
  logic        m_ready = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_ready <= 1'b0;
      m_out   <= 64'd0;
    end else begin
      case (m_phase)
        0: if (start_i && !annul_i) begin
          m_res   <= ref_div(signed_div_i, opdata1_i, opdata2_i);
          m_left  <= (opdata2_i == 32'd0) ? 1 : 32;
          m_phase <= 1;
        end
        1: if (annul_i) begin
          m_phase <= 0;
        end else if (m_left == 1) begin
          m_phase <= 2;
          m_ready <= 1'b1;
          m_out   <= m_res;
        end else begin
          m_left <= m_left - 1;
        end
        default: if (!start_i) begin
          m_phase <= 0;
          m_ready <= 1'b0;
          m_out   <= 64'd0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("model_ready",  64'(ready_o), 64'(m_ready));
    check("model_busy",   64'(busy_o),  64'(m_phase == 1));
    check("model_result", result_o,     m_out);
  end

  task automatic go(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
  endtask

  // Returns edges after acceptance until ready, and the number of busy cycles seen.
  task automatic wait_ready(input logic scramble, output int n, output int nb);
    @(negedge clk);
    n  = 0;
    nb = busy_o ? 1 : 0;
    while (!ready_o && n < 100) begin
      if (scramble) begin
        signed_div_i = 1'($urandom_range(0, 1));
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
      end
      @(negedge clk);
      n++;
      if (busy_o) nb++;
    end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
  endtask

  task automatic drop();
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready",  64'(ready_o), 64'd0);
    check("drop_result", result_o,     64'd0);
  endtask

  task automatic run(input string name, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp);
    int n, nb;
    go(s, a, b);
    wait_ready(1'b0, n, nb);
    check({name, "_latency"}, 64'(n), 64'd32);
    check({name, "_result"},  result_o, exp);
    drop();
  endtask

  initial begin
    int n, nb;
    #1;
    check("rst_ready",  64'(ready_o), 64'd0);
    check("rst_busy",   64'(busy_o),  64'd0);
    check("rst_result", result_o,     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    go(1'b0, 32'd100, 32'd7);
    wait_ready(1'b0, n, nb);
    check("u100_7_latency", 64'(n),  64'd32);
    check("u100_7_busy",    64'(nb), 64'd32);
    check("u100_7_result",  result_o, 64'h00000002_0000000E);
    drop();

    run("s_m7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD);
    run("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    run("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E);
    run("u_ffff_1",  1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF);
    run("u_ovf_pat", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);

    go(1'b0, 32'h12345678, 32'd0);
    wait_ready(1'b0, n, nb);
    check("dbz_latency", 64'(n),   64'd1);
    check("dbz_result",  result_o, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dbz_hold_ready", 64'(ready_o), 64'd1);
      check("dbz_hold_busy",  64'(busy_o),  64'd0);
    end
    drop();

    go(1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    check("annul_busy",  64'(busy_o),  64'd0);
    check("annul_ready", 64'(ready_o), 64'd0);
    repeat (3) @(negedge clk);
    run("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    go(1'b0, 32'd1000, 32'd7);
    wait_ready(1'b1, n, nb);
    check("scramble_latency", 64'(n),   64'd32);
    check("scramble_result",  result_o, 64'h00000006_0000008E);
    drop();

    go(1'b0, 32'hFFFFFFFF, 32'd3);
    @(negedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst     = 1'b1;
    start_i = 1'b0;
    #1;
    check("async_rst_ready",  64'(ready_o), 64'd0);
    check("async_rst_busy",   64'(busy_o),  64'd0);
    check("async_rst_result", result_o,     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst          = 1'b0;
    signed_div_i = 1'b1;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'hFFFFFFF9;
    start_i      = 1'b1;
    wait_ready(1'b0, n, nb);
    check("post_rst_latency", 64'(n),   64'd32);
    check("post_rst_result",  result_o, 64'h00000002_FFFFFFF2);
    drop();

    for (int k = 0; k < 6; k++) begin
      go(1'($urandom_range(0, 1)), $urandom, (k == 5) ? 32'd0 : ($urandom >> (k * 5)));
      wait_ready(1'b0, n, nb);
      drop();
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
